// File: rtl/cart_loader.sv
// Framed byte-stream loader for the cartridge image BRAM.
// Validates magic/length/checksum and writes payload from address 0.
module cart_loader #(
    parameter int unsigned a_bits = 14,
    parameter logic [7:0]  magic  = 8'hCA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [a_bits-1:0] bram_addr,
    output logic [7:0]        bram_data,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAGIC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] cap = 17'd1 << a_bits;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [16:0]       count_q, count_d;
    logic [7:0]        sum_q, sum_d;
    logic [a_bits-1:0] wptr_q, wptr_d;
    logic [a_bits-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;

    logic              ready;
    logic              beat;
    logic [16:0]       len_n;

    assign ready = (state_q == S_MAGIC)  ||
                   (state_q == S_LEN_LO) ||
                   (state_q == S_LEN_HI) ||
                   (state_q == S_DATA)   ||
                   (state_q == S_CSUM);

    assign beat  = in_valid & ready;
    assign len_n = {1'b0, in_data, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        count_d  = count_q;
        sum_d    = sum_q;
        wptr_d   = wptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        done_d   = done_q;
        error_d  = error_q;
        code_d   = code_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_MAGIC;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = 2'b00;
                end
            end
            S_MAGIC: begin
                if (beat) begin
                    if (in_data == magic) begin
                        state_d = S_LEN_LO;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b01;
                    end
                end
            end
            S_LEN_LO: begin
                if (beat) begin
                    len_lo_d = in_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (beat) begin
                    if (len_n == 17'd0 || len_n > cap) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b10;
                    end else begin
                        state_d = S_DATA;
                        count_d = len_n;
                        wptr_d  = '0;
                        sum_d   = 8'd0;
                    end
                end
            end
            S_DATA: begin
                if (beat) begin
                    // write lands one cycle after the accepting beat
                    we_d    = 1'b1;
                    addr_d  = wptr_q;
                    data_d  = in_data;
                    wptr_d  = wptr_q + 1'b1;
                    sum_d   = sum_q + in_data;
                    count_d = count_q - 17'd1;
                    if (count_q == 17'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (beat) begin
                    if (in_data == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b11;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_lo_q <= 8'd0;
            count_q  <= 17'd0;
            sum_q    <= 8'd0;
            wptr_q   <= '0;
            addr_q   <= '0;
            data_q   <= 8'd0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            wptr_q   <= wptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            done_q   <= done_d;
            error_q  <= error_d;
            code_q   <= code_d;
        end
    end

    assign in_ready  = ready;
    assign bram_addr = addr_q;
    assign bram_data = data_q;
    assign bram_we   = we_q;
    assign busy      = ready | we_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_cart_loader.sv
// Randomized bench for cart_loader (a_bits=4) against a frame-level
// reference model and a timed write scoreboard.
module tb_cart_loader;

    localparam int AB  = 4;
    localparam int CAP = 1 << AB;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        longint t;
        int     addr;
        int     data;
    } wr_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AB-1:0] bram_addr;
    logic [7:0]    bram_data;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    int  n_tests;
    int  n_fail;
    wr_t exp_q[$];
    wr_t mon_e;

    cart_loader #(
        .a_bits(AB),
        .magic (8'hCA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bram_addr(bram_addr),
        .bram_data(bram_data),
        .bram_we  (bram_we),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write scoreboard: every bram_we must match the next expected write
    always @(negedge clk) begin
        if (bram_we) begin
            if (exp_q.size() == 0) begin
                check("stray_we", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_time", $time, mon_e.t);
                check("we_addr", bram_addr, mon_e.addr);
                check("we_data", bram_data, mon_e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].t <= $time) begin
            check("missing_we", 0, 1);
            void'(exp_q.pop_front());
        end
    end

    // frame-level reference: outcome code, length, bytes consumed
    function automatic void model(input bq_t b, output int code,
                                  output int n, output int used);
        int s;
        n = 0;
        if (b[0] != 8'hCA) begin
            code = 1;
            used = 1;
            return;
        end
        n = int'(b[1]) + 256 * int'(b[2]);
        if (n == 0 || n > CAP) begin
            code = 2;
            used = 3;
            return;
        end
        s = 0;
        for (int i = 0; i < n; i++) s += int'(b[3+i]);
        code = (int'(b[3+n]) == (s % 256)) ? 0 : 3;
        used = 4 + n;
    endfunction

    function automatic bq_t mk_frame(input int kind);
        bq_t b;
        int n;
        int s;
        logic [7:0] m;
        n = $urandom_range(1, CAP);
        if (kind == 2) n = ($urandom_range(0, 1) == 0) ? 0
                           : $urandom_range(CAP + 1, 65535);
        m = 8'hCA;
        if (kind == 1) begin
            do m = 8'($urandom); while (m == 8'hCA);
        end
        b.push_back(m);
        b.push_back(8'(n));
        b.push_back(8'(n >> 8));
        s = 0;
        for (int i = 0; i < CAP && i < n; i++) begin
            b.push_back(8'($urandom));
            s += int'(b[3+i]);
        end
        if (kind == 3) s += $urandom_range(1, 255);
        b.push_back(8'(s));
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap,
                             output longint t);
        bit ok;
        bit r;
        ok = 0;
        t = 0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            t = $time;
            #1;
            ok = r;
        end
        in_valid = 1'b0;
        if (!ok) check("beat_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input bq_t b, input int maxgap,
                             input bit poke);
        int code;
        int n;
        int used;
        longint t;
        wr_t w;
        model(b, code, n, used);
        pulse_start();
        @(negedge clk);
        check("armed_busy", busy, 1);
        check("armed_done", done, 0);
        check("armed_err", error, 0);
        check("armed_code", err_code, 0);
        check("armed_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < used; i++) begin
            if (poke && i == 3) pulse_start();
            send_byte(b[i], $urandom_range(0, maxgap), t);
            if (i >= 3 && i < 3 + n && (code == 0 || code == 3)) begin
                w.t = t + 5;
                w.addr = i - 3;
                w.data = int'(b[i]);
                exp_q.push_back(w);
            end
        end
        // bytes offered while not ready must be ignored
        in_valid = 1'b1;
        in_data = 8'($urandom);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("done", done, code == 0);
        check("error", error, code != 0);
        check("err_code", err_code, code);
        check("rdy_idle", in_ready, 0);
        check("busy_idle", busy, 0);
        check("writes_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_data();
        longint t;
        wr_t w;
        bq_t b;
        b = '{8'hCA, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i], $urandom_range(0, 2), t);
            if (i >= 3) begin
                w.t = t + 5;
                w.addr = i - 3;
                w.data = int'(b[i]);
                exp_q.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_rdy", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_we", bram_we, 0);
        check("rst_done", done, 0);
        check("rst_err", error, 0);
        check("rst_left", exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t f;
        int s;
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        int s;
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 8'hCA;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("r_rdy", in_ready, 0);
        check("r_we", bram_we, 0);
        check("r_done", done, 0);
        check("r_err", error, 0);
        check("r_code", err_code, 0);
        check("r_busy", busy, 0);
        check("r_addr", bram_addr, 0);
        check("r_data", bram_data, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        f = '{8'hCA, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame(f, 0, 0);
        f = '{8'hCB, 8'h03, 8'h00};
        run_frame(f, 0, 0);
        f = '{8'hCA, 8'h11, 8'h00};
        run_frame(f, 1, 0);
        f = '{8'hCA, 8'h00, 8'h00};
        run_frame(f, 1, 0);
        f = '{8'hCA, 8'h10, 8'h00};
        s = 0;
        for (int i = 0; i < CAP; i++) begin
            f.push_back(8'(i * 7 + 3));
            s += i * 7 + 3;
        end
        f.push_back(8'(s));
        run_frame(f, 0, 0);
        check("last_addr", bram_addr, CAP - 1);
        f = '{8'hCA, 8'h02, 8'h00, 8'hAA, 8'h55, 8'h00};
        run_frame(f, 0, 0);
        f = '{8'hCA, 8'h01, 8'h00, 8'h5A, 8'h5A};
        run_frame(f, 0, 0);

        for (int k = 0; k < 24; k++) begin
            run_frame(mk_frame($urandom_range(0, 3)), 3,
                      $urandom_range(0, 1) == 1);
        end

        reset_mid_data();
        run_frame(mk_frame(0), 2, 0);
        run_frame(mk_frame(0), 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
